// File: rtl/nios2_sopc_pio_knn_resultado_pronto.sv
// nios2_sopc_pio_knn_resultado_pronto
// Avalon-MM input PIO through which the Nios II observes the KNN accelerator's
// "result ready" status lines. Each line is synchronised into clk, edges are
// captured into sticky write-1-to-clear bits, a saturating counter tallies edge
// cycles, and a registered, maskable level interrupt is raised.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word offset: 0 DATA, 1 COUNT, 2 MASK, 3 EDGE
//   chipselect slave select (qualifies writes only)
//   write_n    active-low write strobe
//   writedata  write data
//   in_port    asynchronous status lines from the KNN core
//   readdata   registered read data (valid one clk after address)
//   irq        registered level interrupt
module nios2_sopc_pio_knn_resultado_pronto #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned SYNC_STG  = 2,
  parameter int unsigned EDGE_TYPE = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Index 0 is the stage nearest in_port; the last stage is the synchronised value.
  logic [SYNC_STG-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]               prev_q, prev_d;
  logic [WIDTH-1:0]               edgecapture_q, edgecapture_d;
  logic [WIDTH-1:0]               irq_mask_q, irq_mask_d;
  logic [CNT_W-1:0]               counter_q, counter_d;
  logic [31:0]                    readdata_q, readdata_d;
  logic                           irq_q, irq_d;

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic             any_edge_s;
  logic             wr_s;
  logic             wr_count_s;
  logic             wr_mask_s;
  logic             wr_edge_s;
  logic             unused_wdata_s;

  assign sync_s         = sync_q[SYNC_STG-1];
  assign rise_s         = sync_s & ~prev_q;
  assign fall_s         = ~sync_s & prev_q;
  assign any_edge_s     = |edge_s;
  assign wr_s           = chipselect & ~write_n;
  assign wr_count_s     = wr_s && (address == 2'd1);
  assign wr_mask_s      = wr_s && (address == 2'd2);
  assign wr_edge_s      = wr_s && (address == 2'd3);
  assign unused_wdata_s = ^writedata;

  // Edge selection by EDGE_TYPE; unknown encodings fall back to rising.
  always_comb begin
    edge_s = rise_s;
    case (EDGE_TYPE)
      32'd0:   edge_s = rise_s;
      32'd1:   edge_s = fall_s;
      32'd2:   edge_s = rise_s | fall_s;
      default: edge_s = rise_s;
    endcase
  end

  // Next-state for the synchroniser, edge history, capture and mask registers.
  always_comb begin
    sync_d   = {sync_q[SYNC_STG-2:0], in_port};
    prev_d   = sync_s;
    // A new edge overrides a same-cycle write-1-to-clear.
    if (wr_edge_s) begin
      edgecapture_d = edge_s | (edgecapture_q & ~writedata[WIDTH-1:0]);
    end else begin
      edgecapture_d = edge_s | edgecapture_q;
    end
    if (wr_mask_s) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end else begin
      irq_mask_d = irq_mask_q;
    end
  end

  // Saturating event counter: one count per cycle with any edge; a write clears,
  // but an edge in the same cycle survives as the first new count.
  always_comb begin
    counter_d = counter_q;
    if (wr_count_s) begin
      if (any_edge_s) begin
        counter_d = CNT_ONE;
      end else begin
        counter_d = {CNT_W{1'b0}};
      end
    end else if (any_edge_s && (counter_q != CNT_MAX)) begin
      counter_d = counter_q + CNT_ONE;
    end else begin
      counter_d = counter_q;
    end
  end

  // Read mux (registered, no chipselect qualification) and interrupt level.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      2'd0:    readdata_d = 32'(sync_s);
      2'd1:    readdata_d = 32'(counter_q);
      2'd2:    readdata_d = 32'(irq_mask_q);
      2'd3:    readdata_d = 32'(edgecapture_q);
      default: readdata_d = 32'd0;
    endcase
    irq_d = |(edgecapture_q & irq_mask_q);
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      prev_q        <= {WIDTH{1'b0}};
      edgecapture_q <= {WIDTH{1'b0}};
      irq_mask_q    <= {WIDTH{1'b0}};
      counter_q     <= {CNT_W{1'b0}};
      readdata_q    <= 32'd0;
      irq_q         <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      edgecapture_q <= edgecapture_d;
      irq_mask_q    <= irq_mask_d;
      counter_q     <= counter_d;
      readdata_q    <= readdata_d;
      irq_q         <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios2_sopc_pio_knn_resultado_pronto.sv
// Bench for nios2_sopc_pio_knn_resultado_pronto. Instance A: WIDTH=1, rising
// edges, 16-bit counter. Instance B: WIDTH=4, any edge, 2-bit counter.
module tb_nios2_sopc_pio_knn_resultado_pronto;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [1:0]  a_addr, b_addr;
  logic        a_cs, b_cs, a_wn, b_wn;
  logic [31:0] a_wd, b_wd, a_rd, b_rd;
  logic        a_in;
  logic [3:0]  b_in;
  logic        a_irq, b_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  nios2_sopc_pio_knn_resultado_pronto #(
    .WIDTH(1), .SYNC_STG(2), .EDGE_TYPE(0), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(a_addr), .chipselect(a_cs),
    .write_n(a_wn), .writedata(a_wd), .in_port(a_in), .readdata(a_rd), .irq(a_irq)
  );

  nios2_sopc_pio_knn_resultado_pronto #(
    .WIDTH(4), .SYNC_STG(2), .EDGE_TYPE(2), .CNT_W(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(b_addr), .chipselect(b_cs),
    .write_n(b_wn), .writedata(b_wd), .in_port(b_in), .readdata(b_rd), .irq(b_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Register read: expectation queued at issue, compared when readdata appears.
  task automatic rd(input bit b, input logic [1:0] addr, input logic [31:0] exp, input string tag);
    sb_t e;
    logic [31:0] got;
    @(negedge clk);
    if (b) b_addr = addr; else a_addr = addr;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = b ? b_rd : a_rd;
    e = sb_q.pop_front();
    check(e.tag, got, e.exp);
  endtask

  task automatic wr(input bit b, input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (b) begin b_cs = 1'b1; b_wn = 1'b0; b_addr = addr; b_wd = data; end
    else   begin a_cs = 1'b1; a_wn = 1'b0; a_addr = addr; a_wd = data; end
    @(posedge clk);
    #1;
    a_cs = 1'b0; a_wn = 1'b1; b_cs = 1'b0; b_wn = 1'b1;
  endtask

  task automatic pulse_a();
    @(negedge clk); a_in = 1'b1;
    @(negedge clk); a_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One-clk pulse on A timed so its detected edge coincides with a write.
  task automatic collide_a(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk); a_in = 1'b1;
    @(negedge clk); a_in = 1'b0;
    @(negedge clk);
    a_cs = 1'b1; a_wn = 1'b0; a_addr = addr; a_wd = data;
    @(posedge clk);
    #1;
    a_cs = 1'b0; a_wn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic tog_b(input logic [3:0] m);
    @(negedge clk); b_in = b_in ^ m;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    a_addr = 2'd3; a_cs = 1'b0; a_wn = 1'b1; a_wd = 32'd0; a_in = 1'b1;
    b_addr = 2'd0; b_cs = 1'b0; b_wn = 1'b1; b_wd = 32'd0; b_in = 4'd0;

    // Reset with input high
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", a_rd, 32'd0);
    check("rst_irq", {31'd0, a_irq}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_edge_early", a_rd, 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_on_time", a_rd, 32'd1);
    rd(1'b0, 2'd1, 32'd1, "rst_count");
    wr(1'b0, 2'd3, 32'd1);
    wr(1'b0, 2'd1, 32'd0);
    rd(1'b0, 2'd3, 32'd0, "clr_edge");
    rd(1'b0, 2'd1, 32'd0, "clr_count");

    // Single pulse with mask set, then clear
    wr(1'b0, 2'd2, 32'd1);
    @(negedge clk); a_in = 1'b0;
    repeat (4) @(negedge clk);
    pulse_a();
    rd(1'b0, 2'd3, 32'd1, "pulse_edge");
    rd(1'b0, 2'd1, 32'd1, "pulse_count");
    check("pulse_irq", {31'd0, a_irq}, 32'd1);
    wr(1'b0, 2'd3, 32'd1);
    check("irq_hold_clr_clk", {31'd0, a_irq}, 32'd1);
    @(posedge clk);
    #1;
    check("irq_after_clr", {31'd0, a_irq}, 32'd0);

    // Clear colliding with a new edge
    pulse_a();
    collide_a(2'd3, 32'd1);
    rd(1'b0, 2'd3, 32'd1, "collide_edge");
    check("collide_irq", {31'd0, a_irq}, 32'd1);
    rd(1'b0, 2'd1, 32'd3, "collide_count");

    // Counter
    wr(1'b0, 2'd1, 32'd0);
    for (int i = 0; i < 5; i++) pulse_a();
    rd(1'b0, 2'd1, 32'd5, "count5");
    wr(1'b0, 2'd1, 32'd0);
    rd(1'b0, 2'd1, 32'd0, "count_clr");
    collide_a(2'd1, 32'd0);
    rd(1'b0, 2'd1, 32'd1, "count_clr_edge");

    // Mask
    wr(1'b0, 2'd3, 32'd1);
    wr(1'b0, 2'd2, 32'd0);
    pulse_a();
    rd(1'b0, 2'd3, 32'd1, "masked_edge");
    check("masked_irq", {31'd0, a_irq}, 32'd0);
    wr(1'b0, 2'd2, 32'd1);
    check("unmask_irq_lat", {31'd0, a_irq}, 32'd0);
    @(posedge clk);
    #1;
    check("unmask_irq", {31'd0, a_irq}, 32'd1);
    rd(1'b0, 2'd2, 32'd1, "mask_rd");
    rd(1'b0, 2'd0, 32'd0, "data_low");
    @(negedge clk); a_in = 1'b1;
    repeat (3) @(negedge clk);
    rd(1'b0, 2'd0, 32'd1, "data_high");

    // Instance B: simultaneous toggles, DATA latency
    @(negedge clk); b_addr = 2'd0; b_in = 4'b1001;
    repeat (2) @(posedge clk);
    #1;
    check("b_data_early", b_rd, 32'd0);
    @(posedge clk);
    #1;
    check("b_data_on_time", b_rd, 32'h9);
    rd(1'b1, 2'd3, 32'h9, "b_edge9");
    rd(1'b1, 2'd1, 32'd1, "b_count1");
    wr(1'b1, 2'd3, 32'hF);
    tog_b(4'b0001);
    rd(1'b1, 2'd3, 32'h1, "b_fall_edge");
    rd(1'b1, 2'd1, 32'd2, "b_count2");
    wr(1'b1, 2'd1, 32'd0);
    for (int i = 0; i < 6; i++) tog_b(4'b0010);
    rd(1'b1, 2'd1, 32'd3, "b_count_sat");
    rd(1'b1, 2'd3, 32'h3, "b_edge3");
    check("b_irq_masked", {31'd0, b_irq}, 32'd0);
    wr(1'b1, 2'd2, 32'h2);
    rd(1'b1, 2'd2, 32'h2, "b_mask_rd");
    check("b_irq", {31'd0, b_irq}, 32'd1);
    wr(1'b1, 2'd1, 32'd0);
    rd(1'b1, 2'd1, 32'd0, "b_sat_clr");
    if (sb_q.size() != 0) check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
